// File: rtl/phy_mdio_config.sv
// Clause-22 MDIO master: writes a fixed 3-entry ADIN1300 setup table after reset,
// then reads BMSR at a fixed interval and reports link status.
module phy_mdio_config #(
  parameter int         CLK_DIV       = 10,
  parameter logic [4:0] PHY_ADDR      = 5'd0,
  parameter int         RESET_WAIT    = 50000,
  parameter int         POLL_INTERVAL = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mdio_in,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oen,
  output logic        busy,
  output logic        config_done,
  output logic        link_up,
  output logic        phy_err,
  output logic [15:0] bmsr
);
  localparam int DLY_MAX = (RESET_WAIT > POLL_INTERVAL) ? RESET_WAIT : POLL_INTERVAL;
  localparam int DW      = $clog2(DLY_MAX + 1);
  localparam int CW      = $clog2(CLK_DIV);

  typedef enum logic [2:0] {WAIT_RST, LOAD, SHIFT, GAP, POLL_WAIT} state_t;

  state_t        state_reg, state_next;
  logic [1:0]    idx_reg, idx_next;
  logic          is_read_reg, is_read_next;
  logic [5:0]    bit_cnt_reg, bit_cnt_next;
  logic          gap_cnt_reg, gap_cnt_next;
  logic [DW-1:0] dly_cnt_reg, dly_cnt_next;
  logic          frame_err_reg, frame_err_next;
  logic [15:0]   shift_reg, shift_next;
  logic          mdio_out_reg, mdio_out_next;
  logic          mdio_oen_reg, mdio_oen_next;
  logic          config_done_reg, config_done_next;
  logic          link_up_reg, link_up_next;
  logic          phy_err_reg, phy_err_next;
  logic [15:0]   bmsr_reg, bmsr_next;

  logic [CW-1:0] div_cnt_reg;
  logic          mdc_reg;
  logic          toggle, fall_tick, rise_tick;
  logic [5:0]    nb;
  logic [15:0]   rd_word;
  logic [4:0]    regad;
  logic [15:0]   wr_data;
  logic [63:0]   frame_word;

  // Free-running MDC; the ticks mark the clk edge on which mdc changes level.
  assign toggle    = (div_cnt_reg == CW'(CLK_DIV - 1));
  assign fall_tick = toggle & mdc_reg;
  assign rise_tick = toggle & ~mdc_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_reg <= '0;
      mdc_reg     <= 1'b0;
    end else if (toggle) begin
      div_cnt_reg <= '0;
      mdc_reg     <= ~mdc_reg;
    end else begin
      div_cnt_reg <= div_cnt_reg + CW'(1);
    end
  end

  always_comb begin
    regad   = 5'd1;
    wr_data = 16'h0000;
    if (!is_read_reg) begin
      case (idx_reg)
        2'd0:    begin regad = 5'd4; wr_data = 16'h01E1; end
        2'd1:    begin regad = 5'd9; wr_data = 16'h0000; end
        default: begin regad = 5'd0; wr_data = 16'h1200; end
      endcase
    end
  end

  // Read frames carry ones in TA/data; those bits are never driven.
  assign frame_word = is_read_reg
    ? {32'hFFFF_FFFF, 2'b01, 2'b10, PHY_ADDR, regad, 2'b11, 16'hFFFF}
    : {32'hFFFF_FFFF, 2'b01, 2'b01, PHY_ADDR, regad, 2'b10, wr_data};

  assign nb      = bit_cnt_reg + 6'd1;
  assign rd_word = {shift_reg[14:0], mdio_in};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= WAIT_RST;
      idx_reg         <= 2'd0;
      is_read_reg     <= 1'b0;
      bit_cnt_reg     <= 6'd0;
      gap_cnt_reg     <= 1'b0;
      dly_cnt_reg     <= '0;
      frame_err_reg   <= 1'b0;
      shift_reg       <= 16'h0000;
      mdio_out_reg    <= 1'b1;
      mdio_oen_reg    <= 1'b1;
      config_done_reg <= 1'b0;
      link_up_reg     <= 1'b0;
      phy_err_reg     <= 1'b0;
      bmsr_reg        <= 16'h0000;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      is_read_reg     <= is_read_next;
      bit_cnt_reg     <= bit_cnt_next;
      gap_cnt_reg     <= gap_cnt_next;
      dly_cnt_reg     <= dly_cnt_next;
      frame_err_reg   <= frame_err_next;
      shift_reg       <= shift_next;
      mdio_out_reg    <= mdio_out_next;
      mdio_oen_reg    <= mdio_oen_next;
      config_done_reg <= config_done_next;
      link_up_reg     <= link_up_next;
      phy_err_reg     <= phy_err_next;
      bmsr_reg        <= bmsr_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    idx_next         = idx_reg;
    is_read_next     = is_read_reg;
    bit_cnt_next     = bit_cnt_reg;
    gap_cnt_next     = gap_cnt_reg;
    dly_cnt_next     = dly_cnt_reg;
    frame_err_next   = frame_err_reg;
    shift_next       = shift_reg;
    mdio_out_next    = mdio_out_reg;
    mdio_oen_next    = mdio_oen_reg;
    config_done_next = config_done_reg;
    link_up_next     = link_up_reg;
    phy_err_next     = phy_err_reg;
    bmsr_next        = bmsr_reg;
    case (state_reg)
      WAIT_RST: begin
        if (dly_cnt_reg == DW'(RESET_WAIT - 1)) begin
          dly_cnt_next = '0;
          idx_next     = 2'd0;
          is_read_next = 1'b0;
          state_next   = LOAD;
        end else begin
          dly_cnt_next = dly_cnt_reg + DW'(1);
        end
      end
      LOAD: begin
        if (fall_tick) begin
          bit_cnt_next   = 6'd0;
          frame_err_next = 1'b0;
          mdio_out_next  = frame_word[63];
          mdio_oen_next  = 1'b0;
          state_next     = SHIFT;
        end
      end
      SHIFT: begin
        if (fall_tick) begin
          if (bit_cnt_reg == 6'd63) begin
            mdio_out_next = 1'b1;
            mdio_oen_next = 1'b1;
            gap_cnt_next  = 1'b0;
            state_next    = GAP;
          end else begin
            bit_cnt_next  = nb;
            mdio_out_next = frame_word[6'd63 - nb];
            mdio_oen_next = is_read_reg && (nb >= 6'd46);
          end
        end
        // A PHY that leaves TA high is absent or not answering; keep stale bmsr.
        if (rise_tick && is_read_reg) begin
          if (bit_cnt_reg == 6'd47 && mdio_in) begin
            frame_err_next = 1'b1;
            phy_err_next   = 1'b1;
            link_up_next   = 1'b0;
          end
          if (bit_cnt_reg >= 6'd48) begin
            shift_next = rd_word;
            if (bit_cnt_reg == 6'd63 && !frame_err_reg) begin
              bmsr_next    = rd_word;
              link_up_next = rd_word[2];
            end
          end
        end
      end
      GAP: begin
        if (start && is_read_reg) begin
          config_done_next = 1'b0;
          phy_err_next     = 1'b0;
          idx_next         = 2'd0;
          is_read_next     = 1'b0;
          state_next       = LOAD;
        end else if (fall_tick) begin
          if (gap_cnt_reg) begin
            dly_cnt_next = '0;
            if (is_read_reg) begin
              state_next = POLL_WAIT;
            end else if (idx_reg == 2'd2) begin
              config_done_next = 1'b1;
              state_next       = POLL_WAIT;
            end else begin
              idx_next   = idx_reg + 2'd1;
              state_next = LOAD;
            end
          end else begin
            gap_cnt_next = 1'b1;
          end
        end
      end
      POLL_WAIT: begin
        if (start) begin
          config_done_next = 1'b0;
          phy_err_next     = 1'b0;
          idx_next         = 2'd0;
          is_read_next     = 1'b0;
          state_next       = LOAD;
        end else if (dly_cnt_reg == DW'(POLL_INTERVAL - 1)) begin
          dly_cnt_next = '0;
          is_read_next = 1'b1;
          state_next   = LOAD;
        end else begin
          dly_cnt_next = dly_cnt_reg + DW'(1);
        end
      end
      default: state_next = WAIT_RST;
    endcase
  end

  assign mdc         = mdc_reg;
  assign mdio_out    = mdio_out_reg;
  assign mdio_oen    = mdio_oen_reg;
  assign busy        = (state_reg == LOAD) || (state_reg == SHIFT);
  assign config_done = config_done_reg;
  assign link_up     = link_up_reg;
  assign phy_err     = phy_err_reg;
  assign bmsr        = bmsr_reg;
endmodule
